// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with level tracking, registered status flags,
// programmable almost-full/almost-empty thresholds, sticky overflow/underflow
// capture and an optional first-word-fall-through read port.
module sync_fifo #(
  parameter int data_size          = 8,
  parameter int address_size       = 4,
  parameter int almost_full_level  = 12,
  parameter int almost_empty_level = 2,
  parameter int fwft               = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    write_en,
  input  logic [data_size-1:0]    write_data,
  input  logic                    read_en,
  output logic [data_size-1:0]    read_data,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [address_size:0]   level,
  output logic                    overflow,
  output logic                    underflow,
  input  logic                    clear_errors
);

  localparam int depth = 1 << address_size;

  // Level-width constants so every comparison and increment is width-exact.
  localparam logic [address_size:0] depth_lvl = (address_size + 1)'(depth);
  localparam logic [address_size:0] af_lvl    = (address_size + 1)'(almost_full_level);
  localparam logic [address_size:0] ae_lvl    = (address_size + 1)'(almost_empty_level);
  localparam logic [address_size:0] one_lvl   = (address_size + 1)'(1);

  // Storage; deliberately not reset so it maps onto block RAM.
  logic [data_size-1:0] mem [depth];

  // Pointers carry an extra wrap bit above the array index.
  logic [address_size:0] wptr_reg, wptr_next;
  logic [address_size:0] rptr_reg, rptr_next;
  logic [address_size:0] level_reg, level_next;
  logic full_reg, full_next;
  logic empty_reg, empty_next;
  logic almost_full_reg, almost_full_next;
  logic almost_empty_reg, almost_empty_next;
  logic overflow_reg, overflow_next;
  logic underflow_reg, underflow_next;

  logic write_accept;
  logic read_accept;
  logic [address_size-1:0] waddr;
  logic [address_size-1:0] raddr;

  // Acceptance is judged against the flags registered before this edge, so a
  // read frees no space for a same-edge write and vice versa.
  assign write_accept = write_en && !full_reg;
  assign read_accept  = read_en && !empty_reg;
  assign waddr        = wptr_reg[address_size-1:0];
  assign raddr        = rptr_reg[address_size-1:0];

  // Next-state for pointers, level, status flags and sticky error flags.
  always_comb begin
    wptr_next  = wptr_reg;
    rptr_next  = rptr_reg;
    level_next = level_reg;
    if (write_accept) begin
      wptr_next = wptr_reg + one_lvl;
    end
    if (read_accept) begin
      rptr_next = rptr_reg + one_lvl;
    end
    if (write_accept && !read_accept) begin
      level_next = level_reg + one_lvl;
    end else if (read_accept && !write_accept) begin
      level_next = level_reg - one_lvl;
    end
    // Flags are derived from the post-edge level so they track level exactly.
    full_next         = (level_next == depth_lvl);
    empty_next        = (level_next == '0);
    almost_full_next  = (level_next >= af_lvl);
    almost_empty_next = (level_next <= ae_lvl);
    // A fresh error on the same edge as a clear wins over the clear.
    overflow_next  = (overflow_reg && !clear_errors) || (write_en && full_reg);
    underflow_next = (underflow_reg && !clear_errors) || (read_en && empty_reg);
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_reg         <= '0;
      rptr_reg         <= '0;
      level_reg        <= '0;
      full_reg         <= 1'b0;
      empty_reg        <= 1'b1;
      almost_full_reg  <= 1'b0;
      almost_empty_reg <= 1'b1;
      overflow_reg     <= 1'b0;
      underflow_reg    <= 1'b0;
    end else begin
      wptr_reg         <= wptr_next;
      rptr_reg         <= rptr_next;
      level_reg        <= level_next;
      full_reg         <= full_next;
      empty_reg        <= empty_next;
      almost_full_reg  <= almost_full_next;
      almost_empty_reg <= almost_empty_next;
      overflow_reg     <= overflow_next;
      underflow_reg    <= underflow_next;
    end
  end

  // Array write port; only accepted writes touch storage.
  always_ff @(posedge clk) begin
    if (write_accept) begin
      mem[waddr] <= write_data;
    end
  end

  generate
    if (fwft != 0) begin : g_fwft
      // Head word is presented straight from the array; meaningless while empty.
      assign read_data = mem[raddr];
    end else begin : g_registered
      logic [data_size-1:0] read_data_reg;
      // Registered read: loads only on an accepted pop, holds otherwise.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          read_data_reg <= '0;
        end else if (read_accept) begin
          read_data_reg <= mem[raddr];
        end
      end
      assign read_data = read_data_reg;
    end
  endgenerate

  assign full         = full_reg;
  assign empty        = empty_reg;
  assign almost_full  = almost_full_reg;
  assign almost_empty = almost_empty_reg;
  assign level        = level_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

endmodule
